// File: rtl/demux8_deser_if.sv
// Serial-in / word-out bundle for the 8:1 deserialiser.
// The slave side is the deserialiser; the master side is its producer and consumer.
interface demux8_deser_if #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 3
);
  logic             clr;
  logic             din;
  logic             in_valid;
  logic             in_ready;
  logic [SEL_W-1:0] sel;
  logic [WIDTH-1:0] out_word;
  logic             out_valid;
  logic             out_ready;

  modport slave (
    input  clr, din, in_valid, out_ready,
    output in_ready, sel, out_word, out_valid
  );

  modport master (
    output clr, din, in_valid, out_ready,
    input  in_ready, sel, out_word, out_valid
  );
endinterface

// File: rtl/demux8_deser.sv
// Rebuilds WIDTH-bit words, LSB first, from a serial bit stream and presents them
// on a valid/ready output with one word of skid storage held in the accumulator.
module demux8_deser #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 3
) (
  input logic           clk,
  input logic           rst,
  demux8_deser_if.slave bus
);

  logic [WIDTH-1:0] r_acc;
  logic [SEL_W-1:0] r_sel;
  logic             r_pending;
  logic [WIDTH-1:0] r_out_word;
  logic             r_out_valid;

  logic             w_accept;
  logic             w_xfer;
  logic             w_last;
  logic [WIDTH-1:0] w_word;

  assign w_accept = bus.in_valid && !r_pending;
  assign w_xfer   = r_out_valid && bus.out_ready;
  assign w_last   = (r_sel == SEL_W'(WIDTH - 1));
  assign w_word   = {bus.din, r_acc[WIDTH-2:0]};

  assign bus.in_ready  = !r_pending;
  assign bus.sel       = r_sel;
  assign bus.out_word  = r_out_word;
  assign bus.out_valid = r_out_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc       <= '0;
      r_sel       <= '0;
      r_pending   <= 1'b0;
      r_out_word  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      // A completed word held in the accumulator drains into the output register.
      if (w_xfer) begin
        if (r_pending) begin
          r_out_word <= r_acc;
          r_pending  <= 1'b0;
          r_acc      <= '0;
        end else begin
          r_out_valid <= 1'b0;
        end
      end

      if (bus.clr) begin
        r_sel <= '0;
        if (!r_pending) r_acc <= '0;
      end else if (w_accept) begin
        if (!w_last) begin
          r_acc[r_sel] <= bus.din;
          r_sel        <= r_sel + SEL_W'(1);
        end else begin
          r_sel <= '0;
          // NOTE: non-blocking, so this refill overrides the out_valid clear above
          // in the same cycle and words stream with no bubble.
          if (!r_out_valid || w_xfer) begin
            r_out_word  <= w_word;
            r_out_valid <= 1'b1;
          end else begin
            r_acc[WIDTH-1] <= bus.din;
            r_pending      <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_demux8_deser.sv
// Directed bench for demux8_deser: a word-queue model checked every cycle,
// plus literal expectations at the interesting points of each scenario.
module tb_demux8_deser;

  logic clk = 1'b0;
  logic rst = 1'b1;

  demux8_deser_if #(.WIDTH(8), .SEL_W(3)) bus ();

  demux8_deser #(.WIDTH(8), .SEL_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: completed words waiting to be consumed (front is presented, a second
  // one means the skid slot is full), plus the partial word and its bit count.
  logic [7:0] m_q[$];
  logic [7:0] m_part = '0;
  int         m_cnt  = 0;
  logic [7:0] m_last = '0;
  logic       m_acc_ok;
  logic       m_xfer;
  logic       cmp_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      m_part = '0;
      m_cnt  = 0;
      m_last = '0;
    end else begin
      m_acc_ok = bus.in_valid && (m_q.size() < 2);
      m_xfer   = (m_q.size() > 0) && bus.out_ready;
      if (m_xfer) m_last = m_q.pop_front();
      if (bus.clr) begin
        m_part = '0;
        m_cnt  = 0;
      end else if (m_acc_ok) begin
        m_part[m_cnt] = bus.din;
        if (m_cnt == 7) begin
          m_q.push_back(m_part);
          m_part = '0;
          m_cnt  = 0;
        end else begin
          m_cnt++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model out_valid", 32'(bus.out_valid), 32'(m_q.size() > 0));
      check("model out_word", 32'(bus.out_word), 32'((m_q.size() > 0) ? m_q[0] : m_last));
      check("model in_ready", 32'(bus.in_ready), 32'(m_q.size() < 2));
      check("model sel", 32'(bus.sel), 32'(m_cnt));
    end
  end

  task automatic step(input logic v, input logic d, input logic c);
    bus.in_valid = v;
    bus.din      = d;
    bus.clr      = c;
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic d, input int gap);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.din      = d;
    bus.clr      = 1'b0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.in_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL in_ready wait: got 0 expected 1 within 50 cycles");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_word(input logic [7:0] w, input int gap);
    for (int i = 0; i < 8; i++) send_bit(w[i], gap);
  endtask

  initial begin
    logic [7:0] w;
    bus.in_valid  = 1'b0;
    bus.din       = 1'b0;
    bus.clr       = 1'b0;
    bus.out_ready = 1'b1;

    // Reset then a single word
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    cmp_en = 1'b1;
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset out_word", 32'(bus.out_word), 32'h00);
    check("reset sel", 32'(bus.sel), 32'd0);
    check("reset in_ready", 32'(bus.in_ready), 32'd1);
    w = 8'h09;
    for (int i = 0; i < 7; i++) send_bit(w[i], 0);
    check("09 not yet valid", 32'(bus.out_valid), 32'd0);
    check("09 sel before last", 32'(bus.sel), 32'd7);
    send_bit(w[7], 0);
    check("09 out_valid", 32'(bus.out_valid), 32'd1);
    check("09 out_word", 32'(bus.out_word), 32'h09);
    check("09 sel wrapped", 32'(bus.sel), 32'd0);
    step(1'b0, 1'b0, 1'b0);
    check("09 consumed", 32'(bus.out_valid), 32'd0);
    check("09 word kept", 32'(bus.out_word), 32'h09);

    // Streaming back to back
    send_word(8'hA5, 0);
    check("A5 out_word", 32'(bus.out_word), 32'hA5);
    check("A5 out_valid", 32'(bus.out_valid), 32'd1);
    w = 8'h3C;
    send_bit(w[0], 0);
    check("A5 single pulse", 32'(bus.out_valid), 32'd0);
    for (int i = 1; i < 8; i++) send_bit(w[i], 0);
    check("3C out_word", 32'(bus.out_word), 32'h3C);
    check("3C in_ready", 32'(bus.in_ready), 32'd1);
    step(1'b0, 1'b0, 1'b0);

    // Backpressure with the skid slot filled
    bus.out_ready = 1'b0;
    send_word(8'h12, 0);
    send_word(8'h34, 0);
    check("bp out_word held", 32'(bus.out_word), 32'h12);
    check("bp in_ready low", 32'(bus.in_ready), 32'd0);
    step(1'b1, 1'b1, 1'b0);
    check("bp ignored bit sel", 32'(bus.sel), 32'd0);
    bus.out_ready = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    check("bp drain word", 32'(bus.out_word), 32'h34);
    check("bp drain valid", 32'(bus.out_valid), 32'd1);
    check("bp drain in_ready", 32'(bus.in_ready), 32'd1);
    step(1'b0, 1'b0, 1'b0);
    check("bp 34 consumed", 32'(bus.out_valid), 32'd0);

    // Gaps between bits
    w = 8'hF0;
    for (int i = 0; i < 8; i++) begin
      send_bit(w[i], 3);
      if (i == 2) check("gap sel after 3 bits", 32'(bus.sel), 32'd3);
    end
    check("gap out_word", 32'(bus.out_word), 32'hF0);

    // clr drops a partial word and the same-cycle bit
    for (int i = 0; i < 5; i++) send_bit(1'b1, 0);
    check("clr sel before", 32'(bus.sel), 32'd5);
    step(1'b1, 1'b1, 1'b1);
    check("clr sel after", 32'(bus.sel), 32'd0);
    step(1'b0, 1'b0, 1'b0);
    send_word(8'h81, 0);
    check("clr next word", 32'(bus.out_word), 32'h81);
    check("clr next valid", 32'(bus.out_valid), 32'd1);
    step(1'b0, 1'b0, 1'b0);

    // Reset in the middle of a presented word and a partial one
    bus.out_ready = 1'b0;
    send_word(8'hC3, 0);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 0);
    check("pre-rst valid", 32'(bus.out_valid), 32'd1);
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    check("rst out_valid", 32'(bus.out_valid), 32'd0);
    check("rst out_word", 32'(bus.out_word), 32'h00);
    check("rst sel", 32'(bus.sel), 32'd0);
    check("rst in_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b1;
    send_word(8'h5A, 0);
    check("5A out_word", 32'(bus.out_word), 32'h5A);
    check("5A out_valid", 32'(bus.out_valid), 32'd1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/demux8_deser.md
Name: demux8_deser

Overview:
- Receive-side counterpart of the 8:1 bit-select mux: rebuilds 8-bit words from the serial bit stream the mux produces.
- Steers each accepted serial bit into the word slot given by an internal 3-bit slot counter, LSB first.
- Presents completed words on a valid/ready output with one word of skid buffering.
- Sits in the radix4 datapath wherever a mux-serialised operand must be reassembled in parallel.

Parameters:
- WIDTH, 8, word width in bits; must be a power of two.
- SEL_W, 3, slot counter width; equals log2(WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- clr  input  1  synchronous clear of the partially assembled word only.
- din  input  1  serial data bit.
- in_valid  input  1  din is valid this cycle.
- in_ready  output  1  block can accept din this cycle.
- sel  output  SEL_W  current slot index; the next accepted bit is written to this slot.
- out_word  output  WIDTH  assembled word.
- out_valid  output  1  out_word holds an unconsumed word.
- out_ready  input  1  consumer accepts out_word this cycle.

Behaviour:
- Reset, applied at the clk edge while rst=1: acc=0, sel=0, pending=0, out_word=0, out_valid=0, in_ready=1. rst overrides every other input, including mid-word and mid-handshake; any partial, pending or presented word is discarded.
- Bit accept condition: in_valid && in_ready, where in_ready = !pending (combinational from state).
- On accept with sel<WIDTH-1:
  - acc[sel] <= din.
  - sel <= sel+1.
- On accept with sel==WIDTH-1 (word complete), the complete word is {din, acc[WIDTH-2:0]} and sel wraps to 0:
  - If !out_valid or (out_valid && out_ready): out_word <= word, out_valid <= 1.
  - Otherwise: acc[WIDTH-1] <= din, pending <= 1, in_ready drops the next cycle.
- Latency: last bit accepted in cycle N -> out_valid=1 and out_word stable in cycle N+1.
- Output handshake:
  - Transfer happens when out_valid && out_ready.
  - Without a same-cycle refill, out_valid <= 0 after the transfer; out_word keeps its last value.
  - out_word must not change while out_valid=1 && out_ready=0.
- Pending drain: pending=1 and out_ready=1 -> out_word <= acc, out_valid stays 1, pending <= 0, acc <= 0; in_ready=1 the following cycle.
- Simultaneous word completion and output transfer: the new word loads directly into out_word and pending stays 0, so a word can stream out every WIDTH cycles with no bubble.
- clr (when rst=0):
  - Clears acc and sel.
  - Has priority over a same-cycle bit accept; that bit is dropped.
  - Does not touch out_word, out_valid or pending. If pending=1, clr leaves acc intact so the stored word survives.
- in_valid=0 cycles hold all state; gaps between bits are allowed anywhere.
- in_valid while in_ready=0: the bit is ignored, and the producer must hold it.
- sel always reflects the slot counter, so a bench can compare it against the select value driven at the serialising mux.

Test Plan:
- Reset then word: rst=1 for 2 cycles, then release; feed bits 1,0,0,1,0,0,0,0 (LSB first) on consecutive cycles with out_ready=1 -> out_valid=1 exactly one cycle after the 8th bit, out_word=8'h09, sel back to 0.
- Streaming: feed 8'hA5 then 8'h3C back to back, out_ready=1 -> two single-cycle out_valid pulses 8 cycles apart, values A5 then 3C, in_ready stays 1.
- Backpressure: out_ready=0; feed 8'h12 then 8'h34 -> out_word=12 held stable, in_ready=0 after the 16th bit. Raise out_ready for one cycle -> out_word=34, out_valid stays 1, in_ready=1 the next cycle.
- Bit gaps: feed 8'hF0 with in_valid low for 3 cycles between every bit -> out_word=F0, sel increments only on accepted bits.
- clr mid-word: feed 5 bits of 1s, assert clr together with a 6th bit, then feed 8'h81 -> the 6th bit is dropped, sel=0 after clr, and the next output is 8'h81.
- Reset mid-operation: with out_valid=1 and 3 bits in acc, assert rst -> next cycle out_valid=0, out_word=0, sel=0, in_ready=1. A following word 8'h5A assembles correctly.
